// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller for a FIFO built on a separate memory. It tracks how
// many committed entries have not yet been fetched, fetches them one at a time
// from memory and presents each on a valid/ready output port.
//
// Optional feature macro: FIFO_RD_ALMOST_EMPTY_EN
//   When defined, adds parameter AE_LEVEL and output oALMOST_EMPTY
//   (oCOUNT <= AE_LEVEL, combinational).
//
// Ports:
//   iCLK            clock, all state updates on the rising edge
//   iRST_n          asynchronous active-low reset
//   iWR_PUSH        write side committed one entry to memory this cycle
//   iRD_DATA [W]    memory read data for the address presented by the fetch
//   oRD_EN          registered memory read strobe (one cycle per fetch)
//   oRD_ADDR [AW]   registered memory read address, holds when oRD_EN is low
//   oDATA    [W]    output data to the consumer
//   oVALID          oDATA holds an unconsumed entry
//   iREADY          consumer accepts oDATA
//   oCOUNT   [CW]   entries in memory not yet fetched
//   oEMPTY          nothing buffered anywhere and the FSM is idle
//   oOVF            sticky overflow flag (push while full)
//   oALMOST_EMPTY   (macro only) oCOUNT <= AE_LEVEL
//   oSTATE   [2]    current FSM state (0 IDLE, 1 WAIT, 2 HOLD) for observation
//
// Handshake: an entry is transferred on a rising edge where oVALID && iREADY.
// oVALID never drops and oDATA never changes until that transfer happens;
// iREADY may be driven freely and does not depend on oVALID.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    parameter int AE_LEVEL = 2,
`endif
    parameter int DEPTH = 20,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    input  logic          iWR_PUSH,
    input  logic [W-1:0]  iRD_DATA,
    output logic          oRD_EN,
    output logic [AW-1:0] oRD_ADDR,
    output logic [W-1:0]  oDATA,
    output logic          oVALID,
    input  logic          iREADY,
    output logic [CW-1:0] oCOUNT,
    output logic          oEMPTY,
    output logic          oOVF,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    output logic          oALMOST_EMPTY,
`endif
    output logic [1:0]    oSTATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] rdPtr;

    logic popNow;
    logic fetch;
    logic pushOk;

    // A fetch can start from IDLE, or from HOLD in the same cycle the held
    // entry is consumed, which is what gives back-to-back 2-cycle throughput.
    assign popNow = (state == ST_HOLD) && oVALID && iREADY;
    assign fetch  = (oCOUNT != '0) && ((state == ST_IDLE) || popNow);

    // A push while full is only lost if no fetch frees a slot in that cycle.
    assign pushOk = iWR_PUSH && ((oCOUNT != CW'(DEPTH)) || fetch);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= ST_IDLE;
            rdPtr    <= '0;
            oCOUNT   <= '0;
            oRD_EN   <= 1'b0;
            oRD_ADDR <= '0;
            oDATA    <= '0;
            oVALID   <= 1'b0;
            oOVF     <= 1'b0;
        end else begin
            oRD_EN <= fetch;

            if (fetch) begin
                oRD_ADDR <= rdPtr;
                rdPtr    <= (rdPtr == AW'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
            end

            if (pushOk && !fetch) begin
                oCOUNT <= oCOUNT + 1'b1;
            end else if (!pushOk && fetch) begin
                oCOUNT <= oCOUNT - 1'b1;
            end

            if (iWR_PUSH && !pushOk) begin
                oOVF <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fetch) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Memory data for the address issued last cycle.
                    oDATA  <= iRD_DATA;
                    oVALID <= 1'b1;
                    state  <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (popNow) begin
                        oVALID <= 1'b0;
                        state  <= fetch ? ST_WAIT : ST_IDLE;
                    end
                end
                default: begin
                    oVALID <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign oEMPTY = (oCOUNT == '0) && !oVALID && (state == ST_IDLE);
    assign oSTATE = state;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    localparam logic [31:0] AE_LVL = AE_LEVEL;
    assign oALMOST_EMPTY = (32'(oCOUNT) <= AE_LVL);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Directed bench for fifo_rd_ctrl with DEPTH=20, W=8. A small behavioural
// memory (combinational read at oRD_ADDR) stands in for the FIFO storage; the
// bench's own write pointer fills it and every pushed value is queued as the
// expected delivery order.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int DEPTH = 20;
    localparam int W     = 8;
    localparam int AW    = 5;
    localparam int CW    = 5;

    logic          iCLK;
    logic          iRST_n;
    logic          iWR_PUSH;
    logic [W-1:0]  iRD_DATA;
    logic          oRD_EN;
    logic [AW-1:0] oRD_ADDR;
    logic [W-1:0]  oDATA;
    logic          oVALID;
    logic          iREADY;
    logic [CW-1:0] oCOUNT;
    logic          oEMPTY;
    logic          oOVF;
    logic [1:0]    oSTATE;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic          oALMOST_EMPTY;
`endif

    fifo_rd_ctrl #(
        .DEPTH(DEPTH),
        .W(W)
    ) dut (
        .iCLK(iCLK),
        .iRST_n(iRST_n),
        .iWR_PUSH(iWR_PUSH),
        .iRD_DATA(iRD_DATA),
        .oRD_EN(oRD_EN),
        .oRD_ADDR(oRD_ADDR),
        .oDATA(oDATA),
        .oVALID(oVALID),
        .iREADY(iREADY),
        .oCOUNT(oCOUNT),
        .oEMPTY(oEMPTY),
        .oOVF(oOVF),
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        .oALMOST_EMPTY(oALMOST_EMPTY),
`endif
        .oSTATE(oSTATE)
    );

    // ---------------- clock / reset ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory model and scoreboard state ----------------
    logic [W-1:0]  mem [0:DEPTH-1];
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] addr_log[$];
    int            wp;
    int            n_tests;
    int            n_fail;

    assign iRD_DATA = mem[oRD_ADDR];

    // Record every fetch address for the ordering check.
    always @(posedge iCLK) begin
        #1;
        if (oRD_EN === 1'b1) addr_log.push_back(oRD_ADDR);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        iRST_n   = 1'b0;
        iWR_PUSH = 1'b0;
        iREADY   = 1'b0;
        exp_q.delete();
        wp = 0;
        tick();
        tick();
        iRST_n = 1'b1;
    endtask

    task automatic push_one(input logic [W-1:0] d);
        mem[wp] = d;
        exp_q.push_back(d);
        wp = (wp == DEPTH - 1) ? 0 : wp + 1;
        iWR_PUSH = 1'b1;
        tick();
        iWR_PUSH = 1'b0;
    endtask

    // Wait (bounded) for a valid entry, check it, then let one edge pass so
    // the entry is consumed when iREADY is high.
    task automatic expect_pop(input string tag);
        int k;
        k = 0;
        while (oVALID !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, 32'(oVALID), 32'd1);
        if (oVALID === 1'b1 && exp_q.size() > 0) chk(tag, 32'(oDATA), 32'(exp_q.pop_front()));
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        iRST_n   = 1'b1;
        iWR_PUSH = 1'b0;
        iREADY   = 1'b0;
        n_tests  = 0;
        n_fail   = 0;
        wp       = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset state, checked before any clock edge
        #1 iRST_n = 1'b0;
        #1;
        chk("rst_count", 32'(oCOUNT), 32'd0);
        chk("rst_rd_en", 32'(oRD_EN), 32'd0);
        chk("rst_addr", 32'(oRD_ADDR), 32'd0);
        chk("rst_data", 32'(oDATA), 32'd0);
        chk("rst_valid", 32'(oVALID), 32'd0);
        chk("rst_ovf", 32'(oOVF), 32'd0);
        chk("rst_empty", 32'(oEMPTY), 32'd1);
        chk("rst_state", 32'(oSTATE), 32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        chk("rst_ae", 32'(oALMOST_EMPTY), 32'd1);
`endif
        tick();
        tick();
        iRST_n = 1'b1;

        // Single entry, latency: count update, fetch, capture
        iREADY = 1'b1;
        push_one(8'hA5);
        chk("t1_count1", 32'(oCOUNT), 32'd1);
        chk("t1_no_fetch", 32'(oRD_EN), 32'd0);
        tick();
        chk("t1_fetch", 32'(oRD_EN), 32'd1);
        chk("t1_addr", 32'(oRD_ADDR), 32'd0);
        chk("t1_count0", 32'(oCOUNT), 32'd0);
        tick();
        chk("t1_valid", 32'(oVALID), 32'd1);
        chk("t1_data", 32'(oDATA), 32'(exp_q.pop_front()));
        chk("t1_rd_en_low", 32'(oRD_EN), 32'd0);
        tick();
        chk("t1_valid_gone", 32'(oVALID), 32'd0);
        chk("t1_empty", 32'(oEMPTY), 32'd1);
        chk("t1_count_end", 32'(oCOUNT), 32'd0);

        // Backpressure: three entries, consumer stalled
        iREADY = 1'b0;
        push_one(8'h11);
        push_one(8'h22);
        push_one(8'h33);
        chk("t2_valid", 32'(oVALID), 32'd1);
        chk("t2_data", 32'(oDATA), 32'h11);
        chk("t2_count", 32'(oCOUNT), 32'd2);
        tick();
        tick();
        chk("t2_valid_hold", 32'(oVALID), 32'd1);
        chk("t2_data_hold", 32'(oDATA), 32'h11);
        chk("t2_count_hold", 32'(oCOUNT), 32'd2);
        chk("t2_no_fetch", 32'(oRD_EN), 32'd0);
        iREADY = 1'b1;
        chk("t2_pop0", 32'(oDATA), 32'(exp_q.pop_front()));
        tick();
        chk("t2_gap_valid", 32'(oVALID), 32'd0);
        chk("t2_fetch2", 32'(oRD_EN), 32'd1);
        chk("t2_addr2", 32'(oRD_ADDR), 32'd2);
        tick();
        chk("t2_valid2", 32'(oVALID), 32'd1);
        chk("t2_pop1", 32'(oDATA), 32'(exp_q.pop_front()));
        tick();
        chk("t2_addr3", 32'(oRD_ADDR), 32'd3);
        tick();
        chk("t2_valid3", 32'(oVALID), 32'd1);
        chk("t2_pop2", 32'(oDATA), 32'(exp_q.pop_front()));
        tick();
        chk("t2_empty", 32'(oEMPTY), 32'd1);

        // 25 entries through the pointer wrap
        apply_reset();
        addr_log.delete();
        iREADY = 1'b1;
        for (int i = 0; i < 25; i++) begin
            push_one(8'(i * 7 + 3));
            expect_pop("t3_data");
        end
        tick();
        chk("t3_fetch_count", 32'(addr_log.size()), 32'd25);
        for (int i = 0; i < 25; i++) begin
            if (i < addr_log.size()) chk("t3_addr_seq", 32'(addr_log[i]), 32'(i % 20));
        end
        chk("t3_empty", 32'(oEMPTY), 32'd1);

        // Fill to full while holding, then overflow
        apply_reset();
        iREADY = 1'b0;
        for (int i = 0; i < 21; i++) push_one(8'(8'h40 + i));
        chk("t4_full", 32'(oCOUNT), 32'd20);
        chk("t4_no_ovf", 32'(oOVF), 32'd0);
        chk("t4_valid", 32'(oVALID), 32'd1);
        iWR_PUSH = 1'b1;
        tick();
        iWR_PUSH = 1'b0;
        chk("t4_ovf_count", 32'(oCOUNT), 32'd20);
        chk("t4_ovf", 32'(oOVF), 32'd1);
        chk("t4_pop0", 32'(oDATA), 32'(exp_q.pop_front()));
        iREADY = 1'b1;
        tick();
        chk("t4_count19", 32'(oCOUNT), 32'd19);
        chk("t4_ovf_sticky", 32'(oOVF), 32'd1);
        chk("t4_addr1", 32'(oRD_ADDR), 32'd1);
        for (int i = 0; i < 20; i++) expect_pop("t4_drain");
        chk("t4_empty", 32'(oEMPTY), 32'd1);
        chk("t4_ovf_end", 32'(oOVF), 32'd1);

        // Push and fetch in the same cycle at count 5
        apply_reset();
        iREADY = 1'b0;
        for (int i = 0; i < 6; i++) push_one(8'(8'h80 + i));
        chk("t5_count5", 32'(oCOUNT), 32'd5);
        chk("t5_pop0", 32'(oDATA), 32'(exp_q.pop_front()));
        iREADY = 1'b1;
        push_one(8'hC7);
        chk("t5_count_same", 32'(oCOUNT), 32'd5);
        chk("t5_fetch", 32'(oRD_EN), 32'd1);
        for (int i = 0; i < 6; i++) expect_pop("t5_drain");
        chk("t5_empty", 32'(oEMPTY), 32'd1);

        // Asynchronous reset while a fetch is in flight
        apply_reset();
        iREADY = 1'b0;
        push_one(8'h61);
        push_one(8'h62);
        push_one(8'h63);
        chk("t6_count2", 32'(oCOUNT), 32'd2);
        iREADY = 1'b1;
        tick();
        chk("t6_wait", 32'(oSTATE), 32'd1);
        chk("t6_addr1", 32'(oRD_ADDR), 32'd1);
        #2 iRST_n = 1'b0;
        #1;
        chk("t6_valid", 32'(oVALID), 32'd0);
        chk("t6_count", 32'(oCOUNT), 32'd0);
        chk("t6_addr", 32'(oRD_ADDR), 32'd0);
        chk("t6_rd_en", 32'(oRD_EN), 32'd0);
        chk("t6_empty", 32'(oEMPTY), 32'd1);
        chk("t6_state", 32'(oSTATE), 32'd0);
        tick();
        iRST_n = 1'b1;
        exp_q.delete();
        wp = 0;
        tick();
        tick();
        tick();
        chk("t6_no_stale", 32'(oVALID), 32'd0);
        push_one(8'h5A);
        expect_pop("t6_after");
        chk("t6_end_empty", 32'(oEMPTY), 32'd1);

`ifdef FIFO_RD_ALMOST_EMPTY_EN
        // Almost-empty threshold at the default level of 2
        apply_reset();
        iREADY = 1'b0;
        push_one(8'h01);
        tick();
        tick();
        chk("ae_c0", 32'(oALMOST_EMPTY), 32'd1);
        push_one(8'h02);
        chk("ae_c1", 32'(oALMOST_EMPTY), 32'd1);
        push_one(8'h03);
        chk("ae_c2", 32'(oALMOST_EMPTY), 32'd1);
        push_one(8'h04);
        chk("ae_count3", 32'(oCOUNT), 32'd3);
        chk("ae_c3", 32'(oALMOST_EMPTY), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DEPTH, default 20, number of FIFO memory entries (2 or more).
REQ-002 Parameter W, default 8, data width in bits.
REQ-003 Parameter AW, default $clog2(DEPTH), read address width.
REQ-004 Parameter CW, default $clog2(DEPTH+1), occupancy width.
REQ-005 iCLK  in  1  single clock; all state updates on its rising edge.
REQ-006 iRST_n  in  1  reset, asynchronous, active-low.
REQ-007 iWR_PUSH  in  1  write side committed one entry to memory this cycle.
REQ-008 iRD_DATA  in  W  memory read data, valid the cycle after oRD_EN.
REQ-009 oRD_EN  out  1  registered memory read strobe.
REQ-010 oRD_ADDR  out  AW  registered memory read address.
REQ-011 oDATA  out  W  output data to consumer.
REQ-012 oVALID  out  1  oDATA holds an unconsumed entry.
REQ-013 iREADY  in  1  consumer accepts oDATA when oVALID && iREADY.
REQ-014 oCOUNT  out  CW  entries in memory not yet fetched.
REQ-015 oEMPTY  out  1  oCOUNT==0 && !oVALID && state IDLE.
REQ-016 oOVF  out  1  sticky overflow flag.

Function
REQ-017 States: IDLE (output empty), WAIT (fetch in flight), HOLD (oVALID high).
REQ-018 IDLE: if oCOUNT>0, pulse oRD_EN one cycle with oRD_ADDR=rd_ptr and go to WAIT; else stay.
REQ-019 WAIT: register iRD_DATA into oDATA, set oVALID, go to HOLD; WAIT always lasts exactly one cycle.
REQ-020 HOLD: oDATA and oVALID hold stable while !iREADY.
REQ-021 HOLD on oVALID && iREADY: clear oVALID; if oCOUNT>0, issue the next fetch in the same cycle and go to WAIT; else go to IDLE.
REQ-022 Latency: first push into an empty block gives oVALID high 3 cycles after the iWR_PUSH edge (count update, fetch, capture); sustained throughput is 1 entry per 2 cycles.
REQ-023 rd_ptr advances on every fetch; DEPTH-1 wraps to 0; no other wrap values.
REQ-024 Occupancy next value = oCOUNT + push - fetch, with push and fetch in the same cycle leaving oCOUNT unchanged.
REQ-025 iWR_PUSH while oCOUNT==DEPTH with no fetch in the same cycle: push ignored, oCOUNT stays DEPTH, oOVF set to 1 until reset.
REQ-026 A fetch is never issued when oCOUNT==0, so oCOUNT never underflows.
REQ-027 oRD_EN deasserts in the cycle after any fetch; oRD_ADDR holds its last value when oRD_EN is low.

Reset
REQ-028 iRST_n low immediately forces: state IDLE, rd_ptr 0, oCOUNT 0, oRD_EN 0, oRD_ADDR 0, oDATA 0, oVALID 0, oOVF 0, oEMPTY 1.
REQ-029 Reset in mid-operation (WAIT or HOLD) discards the in-flight or held entry; the block ignores iRD_DATA until a new fetch.
REQ-030 After reset release, the first rising edge is a normal operating cycle.

Configuration
REQ-031 Macro FIFO_RD_ALMOST_EMPTY_EN defined: adds parameter AE_LEVEL (default 2) and output oALMOST_EMPTY, computed combinationally as oCOUNT <= AE_LEVEL; its reset value is 1.
REQ-032 Macro FIFO_RD_ALMOST_EMPTY_EN undefined: neither the AE_LEVEL parameter nor the oALMOST_EMPTY port exists; all other behaviour is identical.

Verification (DEPTH=20, W=8)
REQ-033 Reset, one iWR_PUSH with memory[0]=0xA5, iREADY=1 -> oRD_EN with oRD_ADDR=0, oVALID high with oDATA=0xA5 for one cycle, then oEMPTY=1 and oCOUNT=0.
REQ-034 Push 3 entries with iREADY=0 -> one fetch, oVALID held with oDATA stable, oCOUNT=2; raise iREADY -> remaining 2 entries delivered 2 cycles apart, in order.
REQ-035 Push and pop 25 entries -> oRD_ADDR sequence 0..19 then 0..4, with no skipped or repeated entry.
REQ-036 Fill to oCOUNT=20 while in HOLD with iREADY=0, push once more -> oCOUNT stays 20 and oOVF=1, remaining 1 after a later pop.
REQ-037 iWR_PUSH in the same cycle as a fetch with oCOUNT=5 -> oCOUNT stays 5.
REQ-038 Assert iRST_n low during WAIT -> oVALID=0, oCOUNT=0, oRD_ADDR=0 immediately, without a clock edge; with FIFO_RD_ALMOST_EMPTY_EN defined, oALMOST_EMPTY=1 at oCOUNT 0..2 and 0 at oCOUNT=3.
